// File: rtl/axi_stream_arbiter_pkg.sv
// axis_arb_pkg: shared constants and helpers for the AXI-Stream arbiter.
// Holds the FSM state encoding, a clog2 helper and the m_tid width rule.
package axis_arb_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // A single source still needs a 1-bit tag.
    function automatic int src_id_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_stream_arbiter_if.sv
// axi_stream_arbiter_if: bundle of the N source streams and the shared sink stream.
// Ports: none; signals s_t* (packed per-source, source i at slice i) and m_t*.
// Modports: master = arbiter view (drives s_tready and m_*),
//           slave  = environment view (drives sources and m_tready).
interface axi_stream_arbiter_if
    import axis_arb_pkg::*;
#(
    parameter int num_sources = 4,
    parameter int byte_width  = 4,
    parameter int user_width  = 1
) ();

    localparam int id_w = src_id_width(num_sources);

    logic [num_sources-1:0]              s_tvalid;
    logic [num_sources-1:0]              s_tready;
    logic [num_sources*8*byte_width-1:0] s_tdata;
    logic [num_sources*byte_width-1:0]   s_tkeep;
    logic [num_sources*byte_width-1:0]   s_tstrb;
    logic [num_sources-1:0]              s_tlast;
    logic [num_sources*user_width-1:0]   s_tuser;
    logic                                m_tvalid;
    logic                                m_tready;
    logic [8*byte_width-1:0]             m_tdata;
    logic [byte_width-1:0]               m_tkeep;
    logic [byte_width-1:0]               m_tstrb;
    logic                                m_tlast;
    logic [user_width-1:0]               m_tuser;
    logic [id_w-1:0]                     m_tid;

    modport master (
        input  s_tvalid, s_tdata, s_tkeep, s_tstrb, s_tlast, s_tuser, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tuser, m_tid
    );

    modport slave (
        output s_tvalid, s_tdata, s_tkeep, s_tstrb, s_tlast, s_tuser, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tuser, m_tid
    );

endinterface

// File: rtl/axi_stream_arbiter_rr.sv
// rr_arbiter: combinational winner pick among requesters.
// Ports: req_i (requests), ptr_i (last winner, round-robin build only),
//        winner_o (chosen index), any_req_o (any request present).
// Macro AXIS_ARB_FIXED_PRIORITY_EN: search always starts at 0, ptr_i removed.
module rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int num_sources = 4,
    localparam int id_w        = src_id_width(num_sources)
) (
    input  logic [num_sources-1:0] req_i,
`ifndef AXIS_ARB_FIXED_PRIORITY_EN
    input  logic [id_w-1:0]        ptr_i,
`endif
    output logic [id_w-1:0]        winner_o,
    output logic                   any_req_o
);

    logic [id_w-1:0] idx;

    // Scan from the lowest priority candidate to the highest so the last hit wins.
    always_comb begin
        winner_o = '0;
        idx      = '0;
        for (int k = num_sources - 1; k >= 0; k--) begin
`ifdef AXIS_ARB_FIXED_PRIORITY_EN
            idx = id_w'(k);
`else
            idx = id_w'((int'(ptr_i) + 1 + k) % num_sources);
`endif
            if (req_i[idx]) winner_o = idx;
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/axi_stream_arbiter.sv
// axi_stream_arbiter: N:1 AXI4-Stream arbiter, grant held per packet (through TLAST).
// Ports: clk, resetn (sync, active-low), bus (axi_stream_arbiter_if.master:
//        s_t* sources in / s_tready out, m_t* sink out / m_tready in, m_tid source tag).
// Macro AXIS_ARB_FIXED_PRIORITY_EN: lowest requesting index always wins, no rr pointer.
module axi_stream_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int num_sources = 4,
    parameter  int byte_width  = 4,
    parameter  int user_width  = 1,
    localparam int id_w        = src_id_width(num_sources),
    localparam int dw          = 8 * byte_width
) (
    input  logic                  clk,
    input  logic                  resetn,
    axi_stream_arbiter_if.master  bus
);

    logic [0:0]      state_q, state_d;
    logic [id_w-1:0] grant_q, grant_d;
    logic [id_w-1:0] winner;
    logic            any_req;
    logic            locked;
    logic            eop;

    assign locked = (state_q == ST_LOCKED);
    assign eop    = bus.s_tvalid[grant_q] && bus.m_tready && bus.s_tlast[grant_q];

`ifdef AXIS_ARB_FIXED_PRIORITY_EN
    rr_arbiter #(.num_sources(num_sources)) u_pick (
        .req_i     (bus.s_tvalid),
        .winner_o  (winner),
        .any_req_o (any_req)
    );
`else
    logic [id_w-1:0] rr_ptr_q, rr_ptr_d;

    rr_arbiter #(.num_sources(num_sources)) u_pick (
        .req_i     (bus.s_tvalid),
        .ptr_i     (rr_ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    assign rr_ptr_d = (!locked && any_req) ? winner : rr_ptr_q;

    // Pointer resets to the last index so source 0 is searched first.
    always_ff @(posedge clk) begin
        if (!resetn) rr_ptr_q <= id_w'(num_sources - 1);
        else         rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign state_d = locked ? (eop ? ST_IDLE : ST_LOCKED) : (any_req ? ST_LOCKED : ST_IDLE);
    assign grant_d = (!locked && any_req) ? winner : grant_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Handshake signals are gated by resetn so they drop in the reset cycle itself.
    assign bus.m_tvalid = resetn && locked && bus.s_tvalid[grant_q];
    assign bus.s_tready = (resetn && locked && bus.m_tready) ? (num_sources'(1) << grant_q) : '0;
    assign bus.m_tdata  = bus.s_tdata[int'(grant_q)*dw +: dw];
    assign bus.m_tkeep  = bus.s_tkeep[int'(grant_q)*byte_width +: byte_width];
    assign bus.m_tstrb  = bus.s_tstrb[int'(grant_q)*byte_width +: byte_width];
    assign bus.m_tlast  = bus.s_tlast[grant_q];
    assign bus.m_tuser  = bus.s_tuser[int'(grant_q)*user_width +: user_width];
    assign bus.m_tid    = grant_q;

endmodule

// File: doc/axi_stream_arbiter.md
Name: axi_stream_arbiter

Overview:
N:1 AXI4-Stream arbiter with packet-granular round-robin arbitration. Multiple AXI-Stream sources share one downstream sink. A grant is held from the first beat of a packet through its TLAST beat, so packets are never interleaved. The block sits in front of shared stream consumers (DMA write channel, shared FIFO) and its master port is checked by the AXI-Stream master property set.

Parameters:
num_sources, 4, number of slave (source) ports; legal range 1..16
byte_width, 4, TDATA width in bytes
user_width, 1, TUSER width per beat; must be ≥1
src_id_width, derived = max(1, clog2(num_sources)), width of m_tid source tag (localparam)

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
s_tvalid  in  num_sources  per-source TVALID
s_tready  out  num_sources  per-source TREADY
s_tdata  in  num_sources*8*byte_width  packed per-source TDATA; source i at slice i
s_tkeep  in  num_sources*byte_width  packed TKEEP
s_tstrb  in  num_sources*byte_width  packed TSTRB
s_tlast  in  num_sources  per-source TLAST
s_tuser  in  num_sources*user_width  packed TUSER
m_tvalid  out  1  downstream TVALID
m_tready  in  1  downstream TREADY
m_tdata  out  8*byte_width  muxed TDATA
m_tkeep  out  byte_width  muxed TKEEP
m_tstrb  out  byte_width  muxed TSTRB
m_tlast  out  1  muxed TLAST
m_tuser  out  user_width  muxed TUSER
m_tid  out  src_id_width  index of the granted source

Behaviour:
- States: IDLE, LOCKED. Registers: state, grant_idx, rr_ptr (index of the last granted source).
- Reset (resetn low at clk edge): state=IDLE, grant_idx=0, rr_ptr=num_sources-1, so source 0 wins first.
- m_tvalid and all s_tready are combinationally gated by resetn. While resetn=0 they are 0 in the same cycle.
- IDLE: m_tvalid=0, s_tready=0. If any s_tvalid is set, pick the winner by searching from rr_ptr+1 upward with wrap modulo num_sources. The first set bit wins. Next cycle: state=LOCKED, grant_idx=winner, rr_ptr=winner.
- LOCKED (g=grant_idx):
  - m_tvalid=s_tvalid[g].
  - m_tdata, m_tkeep, m_tstrb, m_tlast, m_tuser = slice g of the source signals.
  - m_tid=g.
  - s_tready[g]=m_tready. All other s_tready=0.
- End of packet: s_tvalid[g] && m_tready && s_tlast[g] returns state to IDLE next cycle.
- Latency: first beat appears on m_* one cycle after the winning s_tvalid is sampled. Data path is combinational in LOCKED, so there is zero added latency per beat.
- Throughput: exactly one bubble cycle per packet (the IDLE arbitration cycle).
- A source that drops s_tvalid mid-packet does not release the grant. The arbiter stays LOCKED until TLAST is handshaken or reset.
- m_tvalid is stable until handshake, provided the granted source obeys AXI-Stream. No arbiter-originated drop of m_tvalid occurs except on reset.
- num_sources=1: grant is always 0. The IDLE/LOCKED sequence is unchanged.
- Reset mid-packet: the packet is abandoned. The next cycle is IDLE with no outputs asserted, and round-robin restarts at source 0.

Optional Feature:
AXIS_ARB_FIXED_PRIORITY_EN
- Defined: fixed priority. The lowest-index requesting source always wins in IDLE, and rr_ptr is unused and removed.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package axis_arb_pkg holds:
  - state encoding localparams (ST_IDLE=1'b0, ST_LOCKED=1'b1);
  - clog2 function;
  - the derived src_id_width rule.
- Sub-module rr_arbiter contains only the combinational pick: inputs req[num_sources] and ptr; outputs winner index and any_req. Under the macro, its search start is fixed at 0.
- The top module holds the state register, grant register and stream mux.

Test Plan:
1. Reset, then s_tvalid=4'b0001, 3-beat packet from source 0, m_tready=1 → m_tvalid high cycles 2–4, m_tid=0, m_tlast on beat 3, then IDLE.
2. All four sources valid with 1-beat packets, m_tready=1 → grant order 0,1,2,3,0; one idle cycle between packets. With AXIS_ARB_FIXED_PRIORITY_EN → order 0,0,0…
3. Source 2 granted, m_tready toggled 1,0,0,1 mid-packet → m_tdata/m_tlast stable while stalled, s_tready[2] mirrors m_tready, s_tready[others]=0.
4. Source 1 locked, source 3 raises tvalid mid-packet → source 3 is not granted until the cycle after source 1's TLAST handshake.
5. resetn=0 during beat 2 of a 4-beat packet → m_tvalid=0 and s_tready=0 in the same cycle; after release, source 0 wins first if valid.
6. Run the AXI-Stream master property set bound to the m_* port under random legal source stimulus → no assertion failures in 30-step BMC.
